// File: rtl/dtw_accumulator.sv
// Dynamic-time-warping cost accumulator: consumes local distances row-major and
// produces the saturating accumulated cost D(n_rows-1, n_cols-1) using a single row buffer.
module dtw_accumulator #(
    parameter int DIST_W   = 12,
    parameter int ACC_W    = 20,
    parameter int MAX_COLS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [6:0]        n_cols,
    input  logic [15:0]       n_rows,
    input  logic              dist_valid,
    input  logic [DIST_W-1:0] dist_in,
    output logic              dist_ready,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  result,
    output logic              sat,
    output logic [1:0]        dbg_state
);
    localparam int AW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Handshake: an element transfers on a rising edge where dist_valid && dist_ready;
    // dist_ready depends only on the registered state, so a stalled source never loses data.
    state_t           state_q;
    logic [6:0]       col_q, ncols_q;
    logic [15:0]      row_q, nrows_q;
    logic [ACC_W-1:0] left_q, diag_q, result_q;
    logic             sat_q;
    logic [ACC_W-1:0] row_buf [MAX_COLS];

    logic             accept;
    logic             legal_start;
    logic             last_col, last_row;
    logic [ACC_W-1:0] up_val, min_ul, min3, base_val, cell_d;
    logic [ACC_W:0]   sum_wide;

    assign accept      = (state_q == S_RUN) && dist_valid;
    assign legal_start = (n_cols != 7'd0) && ({25'd0, n_cols} <= 32'(MAX_COLS)) && (n_rows != 16'd0);
    assign last_col    = (col_q == ncols_q - 7'd1);
    assign last_row    = (row_q == nrows_q - 16'd1);
    assign up_val      = row_buf[col_q[AW-1:0]];

    always_comb begin
        min_ul   = (up_val < left_q) ? up_val : left_q;
        min3     = (min_ul < diag_q) ? min_ul : diag_q;
        base_val = min3;
        if (row_q == 16'd0 && col_q == 7'd0) begin
            base_val = '0;
        end else if (row_q == 16'd0) begin
            base_val = left_q;
        end else if (col_q == 7'd0) begin
            base_val = up_val;
        end
        sum_wide = {1'b0, base_val} + {{(ACC_W + 1 - DIST_W){1'b0}}, dist_in};
        // The carry-out of the widened add is the saturation indicator.
        cell_d   = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            ncols_q  <= '0;
            nrows_q  <= '0;
            left_q   <= '0;
            diag_q   <= '0;
            result_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && legal_start) begin
                        state_q  <= S_RUN;
                        ncols_q  <= n_cols;
                        nrows_q  <= n_rows;
                        col_q    <= '0;
                        row_q    <= '0;
                        left_q   <= '0;
                        diag_q   <= '0;
                        result_q <= '0;
                        sat_q    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        left_q <= cell_d;
                        diag_q <= up_val;
                        if (sum_wide[ACC_W]) begin
                            sat_q <= 1'b1;
                        end
                        if (last_col) begin
                            col_q <= '0;
                            if (last_row) begin
                                state_q  <= S_DONE;
                                result_q <= cell_d;
                            end else begin
                                row_q <= row_q + 16'd1;
                            end
                        end else begin
                            col_q <= col_q + 7'd1;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Entry j holds D(i-1,j) until column j of row i replaces it; row 0 never reads it.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            row_buf[col_q[AW-1:0]] <= cell_d;
        end
    end

    assign dist_ready = (state_q == S_RUN);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign result     = result_q;
    assign sat        = sat_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_dtw_accumulator.sv
// Directed bench for dtw_accumulator: hand-computed costs, stalls, saturation,
// illegal/ignored starts and mid-pass reset, checked with immediate assertions.
module tb_dtw_accumulator;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  n_cols;
    logic [15:0] n_rows;
    logic        dist_valid;
    logic [11:0] dist_in;

    logic        dist_ready, busy, done, sat;
    logic [19:0] result;
    logic [1:0]  dbg_state;

    logic        s_dist_ready, s_busy, s_done, s_sat;
    logic [12:0] s_result;
    logic [1:0]  s_dbg_state;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    dtw_accumulator u_dut (
        .clk(clk), .rst(rst), .start(start), .n_cols(n_cols), .n_rows(n_rows),
        .dist_valid(dist_valid), .dist_in(dist_in),
        .dist_ready(dist_ready), .busy(busy), .done(done), .result(result),
        .sat(sat), .dbg_state(dbg_state)
    );

    dtw_accumulator #(.DIST_W(12), .ACC_W(13), .MAX_COLS(64)) u_sat (
        .clk(clk), .rst(rst), .start(start), .n_cols(n_cols), .n_rows(n_rows),
        .dist_valid(dist_valid), .dist_in(dist_in),
        .dist_ready(s_dist_ready), .busy(s_busy), .done(s_done), .result(s_result),
        .sat(s_sat), .dbg_state(s_dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Called at a falling edge; leaves the bench one falling edge after the start pulse.
    task automatic start_pass(input logic [6:0] c, input logic [15:0] r);
        start = 1'b1; n_cols = c; n_rows = r;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input logic [11:0] d, input int gap);
        check("ready_before_accept", {31'd0, dist_ready}, 32'd1);
        check("no_early_done", {31'd0, done}, 32'd0);
        dist_valid = 1'b1; dist_in = d;
        @(negedge clk);
        dist_valid = 1'b0;
        repeat (gap) begin
            check("ready_during_stall", {31'd0, dist_ready}, 32'd1);
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; n_cols = 7'd0; n_rows = 16'd0;
        dist_valid = 1'b0; dist_in = 12'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, dist_ready}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {12'd0, result}, 32'd0);
        check("rst_sat", {31'd0, sat}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1x1, d=5
        start_pass(7'd1, 16'd1);
        check("p1_busy", {31'd0, busy}, 32'd1);
        feed(12'd5, 0);
        check("p1_ready_low", {31'd0, dist_ready}, 32'd0);
        check("p1_done", {31'd0, done}, 32'd1);
        check("p1_result", {12'd0, result}, 32'd5);
        check("p1_sat", {31'd0, sat}, 32'd0);
        @(negedge clk);
        check("p1_done_one_cycle", {31'd0, done}, 32'd0);
        check("p1_idle", {31'd0, busy}, 32'd0);
        check("p1_result_hold", {12'd0, result}, 32'd5);

        // 2x2 back-to-back: D00=1 D01=3 D10=4 D11=5
        start_pass(7'd2, 16'd2);
        check("p2_result_cleared", {12'd0, result}, 32'd0);
        feed(12'd1, 0); check("p2_D00", {12'd0, u_dut.left_q}, 32'd1);
        feed(12'd2, 0); check("p2_D01", {12'd0, u_dut.left_q}, 32'd3);
        feed(12'd3, 0); check("p2_D10", {12'd0, u_dut.left_q}, 32'd4);
        feed(12'd4, 0); check("p2_D11", {12'd0, u_dut.left_q}, 32'd5);
        check("p2_done", {31'd0, done}, 32'd1);
        check("p2_result", {12'd0, result}, 32'd5);
        @(negedge clk);

        // Same 2x2 with 3-cycle bubbles between elements
        start_pass(7'd2, 16'd2);
        feed(12'd1, 3); feed(12'd2, 3); feed(12'd3, 3); feed(12'd4, 0);
        check("p3_done", {31'd0, done}, 32'd1);
        check("p3_result", {12'd0, result}, 32'd5);
        @(negedge clk);

        // 3x3 exercising the diagonal path: rows 1 6 8 / 4 2 6 / 6 8 3
        start_pass(7'd3, 16'd3);
        feed(12'd1, 0); feed(12'd5, 0); feed(12'd2, 0);
        feed(12'd3, 0); feed(12'd1, 0); check("p4_D11", {12'd0, u_dut.left_q}, 32'd2);
        feed(12'd4, 0); check("p4_D12", {12'd0, u_dut.left_q}, 32'd6);
        feed(12'd2, 0); feed(12'd6, 0); check("p4_D21", {12'd0, u_dut.left_q}, 32'd8);
        feed(12'd1, 0);
        check("p4_done", {31'd0, done}, 32'd1);
        check("p4_result", {12'd0, result}, 32'd3);
        @(negedge clk);

        // 1x3 of 4095: the ACC_W=13 instance saturates on the third element
        start_pass(7'd3, 16'd1);
        feed(12'd4095, 0); check("sat_D00", {19'd0, u_sat.left_q}, 32'd4095);
        feed(12'd4095, 0); check("sat_D01", {19'd0, u_sat.left_q}, 32'd8190);
        check("sat_not_yet", {31'd0, s_sat}, 32'd0);
        feed(12'd4095, 0);
        check("sat_done", {31'd0, s_done}, 32'd1);
        check("sat_result", {19'd0, s_result}, 32'd8191);
        check("sat_flag", {31'd0, s_sat}, 32'd1);
        check("wide_result", {12'd0, result}, 32'd12285);
        check("wide_no_sat", {31'd0, sat}, 32'd0);
        repeat (3) @(negedge clk);
        check("sat_hold", {31'd0, s_sat}, 32'd1);
        check("sat_result_hold", {19'd0, s_result}, 32'd8191);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_clears_sat", {31'd0, s_sat}, 32'd0);
        check("rst_clears_result", {19'd0, s_result}, 32'd0);

        // Saturate again, then a fresh start must clear sat and result
        start_pass(7'd3, 16'd1);
        feed(12'd4095, 0); feed(12'd4095, 0); feed(12'd4095, 0);
        check("sat2_flag", {31'd0, s_sat}, 32'd1);
        @(negedge clk);
        start_pass(7'd1, 16'd1);
        check("start_clears_sat", {31'd0, s_sat}, 32'd0);
        check("start_clears_result", {19'd0, s_result}, 32'd0);
        feed(12'd1, 0);
        check("after_clear_result", {19'd0, s_result}, 32'd1);
        @(negedge clk);

        // Reset after third accept of a 2x2 pass; a pending fourth element is dropped
        start_pass(7'd2, 16'd2);
        feed(12'd1, 0); feed(12'd2, 0); feed(12'd3, 0);
        rst = 1'b1; dist_valid = 1'b1; dist_in = 12'd4;
        @(negedge clk);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_ready", {31'd0, dist_ready}, 32'd0);
        check("mid_rst_result", {12'd0, result}, 32'd0);
        check("mid_rst_left", {12'd0, u_dut.left_q}, 32'd0);
        check("mid_rst_state", {30'd0, dbg_state}, 32'd0);
        rst = 1'b0; dist_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_no_done", {31'd0, done}, 32'd0);
        start_pass(7'd1, 16'd1);
        feed(12'd7, 0);
        check("post_rst_done", {31'd0, done}, 32'd1);
        check("post_rst_result", {12'd0, result}, 32'd7);
        @(negedge clk);

        // Illegal lengths are ignored
        start_pass(7'd0, 16'd1);
        check("ncols0_ignored", {31'd0, busy}, 32'd0);
        start_pass(7'd65, 16'd1);
        check("ncols65_ignored", {31'd0, busy}, 32'd0);
        start_pass(7'd1, 16'd0);
        check("nrows0_ignored", {31'd0, busy}, 32'd0);

        // Maximum template length: 1x64 of ones
        start_pass(7'd64, 16'd1);
        check("max_cols_busy", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 64; k++) feed(12'd1, 0);
        check("max_cols_done", {31'd0, done}, 32'd1);
        check("max_cols_result", {12'd0, result}, 32'd64);
        @(negedge clk);

        // Start pulsed during RUN and during DONE must be ignored
        start_pass(7'd2, 16'd2);
        feed(12'd1, 0); feed(12'd2, 0);
        start_pass(7'd1, 16'd1);
        check("run_start_state", {30'd0, dbg_state}, 32'd1);
        feed(12'd3, 0); feed(12'd4, 0);
        check("run_start_done", {31'd0, done}, 32'd1);
        check("run_start_result", {12'd0, result}, 32'd5);
        start_pass(7'd1, 16'd1);
        check("done_start_ignored", {31'd0, busy}, 32'd0);
        check("done_start_result_hold", {12'd0, result}, 32'd5);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/dtw_accumulator.md
DTW_ACCUMULATOR -- requirements
Module: dtw_accumulator

Interface
REQ-001 SHALL have parameter DIST_W, default 12: width of the unsigned local distance d(i,j).
REQ-002 SHALL have parameter ACC_W, default 20: width of the unsigned accumulated cost D(i,j); ACC_W > DIST_W.
REQ-003 SHALL have parameter MAX_COLS, default 64: row-buffer depth and maximum template length.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  begins a matrix pass; sampled only in IDLE.
REQ-007 n_cols  in  7  template length (columns), legal range 1..MAX_COLS; sampled with start.
REQ-008 n_rows  in  16  sample length (rows), legal range >=1; sampled with start.
REQ-009 dist_valid  in  1  dist_in carries the next d(i,j).
REQ-010 dist_in  in  DIST_W  local distance, unsigned.
REQ-011 dist_ready  out  1  element can be accepted this cycle.
REQ-012 busy  out  1  high in RUN and DONE.
REQ-013 done  out  1  one-cycle pulse when result is final.
REQ-014 result  out  ACC_W  D(n_rows-1, n_cols-1).
REQ-015 sat  out  1  some D(i,j) in the current pass saturated.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
- IDLE -> RUN: start=1, n_cols in 1..MAX_COLS, n_rows>=1.
- RUN -> DONE: last element accepted.
- DONE -> IDLE: unconditionally after 1 cycle.
REQ-017 start with an illegal length (n_cols=0, n_cols>MAX_COLS, or n_rows=0) SHALL be ignored; FSM stays in IDLE.
REQ-018 start SHALL be ignored in RUN and DONE.
REQ-019 dist_ready SHALL be high in RUN only; an element is accepted when dist_valid && dist_ready.
REQ-020 Elements SHALL be consumed row-major: (0,0), (0,1) .. (0,n_cols-1), (1,0) ..; column counter wraps to 0 and row counter increments after column n_cols-1.
REQ-021 SHALL compute:
- D(0,0)=d
- D(0,j)=d+D(0,j-1)
- D(i,0)=d+D(i-1,0)
- otherwise d+min(D(i-1,j), D(i,j-1), D(i-1,j-1))
REQ-022 Previous-row values SHALL be held in a MAX_COLS x ACC_W row buffer.
- Accepting (i,j) reads entry j as D(i-1,j), then overwrites it with D(i,j) in the same cycle.
- The value read SHALL be registered as diag for column j+1.
- The new D(i,j) SHALL be registered as left.
REQ-023 Addition SHALL saturate at 2^ACC_W-1; any saturation sets sat, which holds until the next accepted start or reset.
REQ-024 Min-tie SHALL be irrelevant to the result; all comparisons are unsigned.
REQ-025 Throughput SHALL be one element per cycle; dist_valid bubbles stall without changing state.
REQ-026 done SHALL be asserted (state DONE) the cycle after the final element is accepted, with result valid in that same cycle.
REQ-027 result and sat SHALL hold after DONE until the next accepted start, which clears both to 0.
REQ-028 Row-buffer contents SHALL NOT need clearing; row 0 never reads the buffer.

Reset
REQ-029 rst=1 SHALL force IDLE, row/column counters 0, left/diag 0, result 0, sat 0, done 0, busy 0, dist_ready 0, regardless of state.
REQ-030 rst asserted mid-pass SHALL abandon the pass with no done pulse; the next legal start SHALL run a fresh pass correctly.

Verification
REQ-031 1x1, d=5 -> dist_ready high 1 cycle; done 1 cycle later; result=5, sat=0.
REQ-032 2x2, d=[1,2;3,4], back-to-back valid -> D01=3, D10=4, D11=5; result=5; done exactly 1 cycle after 4th accept.
REQ-033 Same 2x2 with dist_valid low for 3 cycles between each element -> result=5; done 1 cycle after final accept.
REQ-034 ACC_W=13, 1x3, d=4095 each -> 4095, 8190, then saturate: result=8191, sat=1; next start clears sat.
REQ-035 2x2 pass, rst after 3rd accept -> all outputs 0 next cycle, no done; then 1x1 d=7 -> result=7.
REQ-036 start with n_cols=0, then with n_cols=65, then start pulsed during RUN -> FSM unaffected each time; the running pass completes with the correct result.
